nand_flash_ctrl: RTL
====================

# nand_flash_ctrl

Host-side NAND flash memory controller that drives the memory-module bus (DIO, ALE, CLE, wEn, rEn, cEn, status). It accepts one host request at a time: page read, page program or block erase. For each request it sequences command, address and data phases onto the shared 16-bit tri-state bus, waits for the memory's status handshake, and returns read data or completion to the host. It sits directly upstream of the memory module.

## Interface
- DIOWidth, 16, width of multiplexed DIO bus, host address and data
- PageWords, 4, words per page transfer (≥1)
- TimeoutCycles, 1024, WAIT_STATUS watchdog limit (used only with NFC_TIMEOUT_EN)

- clk  input  1  clock, all logic on rising edge
- rstN  input  1  asynchronous, active-low reset
- cmdValid  input  1  host request valid
- cmdReady  output  1  controller idle, accepts request
- cmdOp  input  2  00 read, 01 program, 10 erase, 11 reserved
- cmdAddr  input  DIOWidth  page/block address
- wrData  input  DIOWidth  program data word
- wrValid  input  1  wrData valid
- wrReady  output  1  controller consumes wrData this cycle
- rdData  output  DIOWidth  read data word
- rdValid  output  1  rdData valid, one-cycle pulse per word
- done  output  1  one-cycle request-complete pulse
- error  output  1  one-cycle pulse with done on timeout or reserved op
- DIO_memCntrl  inout  DIOWidth  tri-state bus, driven only when wEn=1
- ALE, CLE, wEn, rEn, cEn  output  1 each  active-high memory strobes
- status  input  1  memory ready/complete, level

## Operation
- Command codes: READ 0x0000/0x0030, PROG 0x0080/0x0010, ERASE 0x0060/0x00D0.
- States: IDLE, CMD, ADDR, WDATA, CONF, WAIT_ST, RDATA, DONE.
- IDLE: cmdReady=1. On cmdValid, latch cmdOp/cmdAddr and go to CMD. Reserved op goes directly to DONE with error=1 and no bus activity.
- CMD: CLE=wEn=1, DIO=first code. Next: ADDR.
- ADDR: ALE=wEn=1, DIO=latched addr. Next: WDATA for program, CONF otherwise.
- WDATA: wrReady=1. Each cycle wrValid=1 drives wEn=1, DIO=wrData and increments the word counter. wrValid=0 gives wEn=0 with the bus released (stall). After PageWords words go to CONF.
- CONF: CLE=wEn=1, DIO=second code. Next: WAIT_ST.
- WAIT_ST: waits for status=1. Next: RDATA for read, DONE otherwise.
- RDATA: rEn=1 for PageWords consecutive cycles. DIO is sampled at each rising edge ending an rEn cycle. rdData/rdValid are registered and appear the cycle after each rEn cycle. Next: DONE.
- DONE: done=1 for one cycle, cEn=0. Next: IDLE.
- cEn=1 from CMD through RDATA/WAIT_ST inclusive. Never more than one of ALE/CLE is high. wEn and rEn are never both high.
- Word counter width $clog2(PageWords+1). It resets to 0 on entry to WDATA/RDATA and never wraps mid-transfer.
- cmdValid outside IDLE is ignored (cmdReady=0).
- A status=1 that arrives before WAIT_ST is ignored. Only the level inside WAIT_ST counts.

## Timing
- Reset values: all strobes 0, cmdReady=1 after reset, wrReady/rdValid/done/error 0, rdData 0, DIO high-Z, state IDLE, counters 0.
- Reset asserted mid-operation forces the above asynchronously, including immediate bus release.
- Erase with status already high: accept edge → CMD, ADDR, CONF, WAIT_ST, DONE. done is high 5 cycles after the accept edge.
- Read: done follows the last rdValid by 0 cycles (same cycle).
- The bus is never driven in the cycle after an rEn cycle (turnaround guaranteed by RDATA → DONE).

## Configuration
- NFC_TIMEOUT_EN defined: the watchdog counts WAIT_ST cycles. On reaching TimeoutCycles it moves to DONE with done=1 and error=1 and skips RDATA.
- NFC_TIMEOUT_EN undefined: WAIT_ST waits indefinitely, and error is asserted only for a reserved op.

## Structure
- Package nfc_pkg holds the op enum, state enum and the six command-code constants.
- Sub-module nfc_watchdog holds the clear/enable/expired counter. It is instantiated only under NFC_TIMEOUT_EN.

## Test plan
- Erase, addr 0x1234, status pulled high after 3 cycles in WAIT_ST → DIO sequence 0x0060, 0x1234, 0x00D0; single done, error=0.
- Program, addr 0x0042, data 0xA5A5/0x5A5A/0xFFFF/0x0001, wrValid low for 2 cycles after the second word → wEn gaps match the stall, 4 data words in order, then 0x0010.
- Read, addr 0x0007, memory returns 0x1111..0x4444 → 4 rdValid pulses in order, done coincident with the last pulse.
- Reserved op 11 → done=error=1 one cycle after accept; cEn, wEn, CLE, ALE stay 0.
- With NFC_TIMEOUT_EN and TimeoutCycles=16, status held low → done=error=1 after 16 WAIT_ST cycles, no rEn.
- rstN low during WDATA → DIO high-Z and cEn=0 immediately, cmdReady=1 after release, next erase completes normally.

Source files
------------

// File: rtl/nfc_pkg.sv
// Shared types and NAND command codes for the host-side flash controller.
package nfc_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_PROG  = 2'b01,
    OP_ERASE = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_CONF,
    ST_WAIT,
    ST_RDATA,
    ST_DONE
  } state_e;

  localparam logic [15:0] CMD_READ_1  = 16'h0000;
  localparam logic [15:0] CMD_READ_2  = 16'h0030;
  localparam logic [15:0] CMD_PROG_1  = 16'h0080;
  localparam logic [15:0] CMD_PROG_2  = 16'h0010;
  localparam logic [15:0] CMD_ERASE_1 = 16'h0060;
  localparam logic [15:0] CMD_ERASE_2 = 16'h00D0;

  function automatic logic [15:0] first_code(input op_e op);
    case (op)
      OP_READ: return CMD_READ_1;
      OP_PROG: return CMD_PROG_1;
      default: return CMD_ERASE_1;
    endcase
  endfunction

  function automatic logic [15:0] second_code(input op_e op);
    case (op)
      OP_READ: return CMD_READ_2;
      OP_PROG: return CMD_PROG_2;
      default: return CMD_ERASE_2;
    endcase
  endfunction

endpackage

// File: rtl/nfc_watchdog.sv
// WAIT_ST watchdog: counts enabled cycles, flags expiry on the Limit-th cycle.
// Only instantiated when NFC_TIMEOUT_EN is defined.
module nfc_watchdog #(
  parameter int unsigned Limit = 1024
) (
  input  logic clk,
  input  logic rstN,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(Limit + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  // count holds completed cycles, so the current cycle is number count+1
  assign expired = enable && (count == CW'(Limit - 1));

endmodule

// File: rtl/nand_flash_ctrl.sv
// NAND flash host controller: sequences read/program/erase onto the shared DIO bus.
// Optional WAIT_ST watchdog enabled with `define NFC_TIMEOUT_EN.
module nand_flash_ctrl
  import nfc_pkg::*;
#(
  parameter int DIOWidth      = 16,
  parameter int PageWords     = 4,
  parameter int TimeoutCycles = 1024
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                cmdValid,
  output logic                cmdReady,
  input  logic [1:0]          cmdOp,
  input  logic [DIOWidth-1:0] cmdAddr,
  input  logic [DIOWidth-1:0] wrData,
  input  logic                wrValid,
  output logic                wrReady,
  output logic [DIOWidth-1:0] rdData,
  output logic                rdValid,
  output logic                done,
  output logic                error,
  inout  wire  [DIOWidth-1:0] DIO_memCntrl,
  output logic                ALE,
  output logic                CLE,
  output logic                wEn,
  output logic                rEn,
  output logic                cEn,
  input  logic                status,
  output state_e              dbgState
);

  localparam int CW = $clog2(PageWords + 1);
  localparam logic [CW-1:0] LastWord = CW'(PageWords - 1);

  // Handshakes: a request is taken on a rising edge with cmdValid && cmdReady;
  // a write word is taken on a rising edge with wrValid && wrReady; rdValid and
  // done are single-cycle pulses with no back-pressure.
  state_e              state;
  op_e                 op_q;
  logic [DIOWidth-1:0] addr_q;
  logic [DIOWidth-1:0] dio_q;
  logic [CW-1:0]       cnt;
  logic                wen_q;
  logic                wr_word;
  logic                wd_expired;

  // Write data goes straight to the bus in the cycle the host presents it
  assign wr_word      = wrReady && wrValid;
  assign wEn          = wen_q || wr_word;
  assign DIO_memCntrl = wEn ? (wr_word ? wrData : dio_q) : 'z;
  assign dbgState     = state;

`ifdef NFC_TIMEOUT_EN
  nfc_watchdog #(.Limit(TimeoutCycles)) u_watchdog (
    .clk     (clk),
    .rstN    (rstN),
    .clear   (state != ST_WAIT),
    .enable  (state == ST_WAIT),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= ST_IDLE;
      op_q     <= OP_READ;
      addr_q   <= '0;
      dio_q    <= '0;
      cnt      <= '0;
      wen_q    <= 1'b0;
      cmdReady <= 1'b1;
      wrReady  <= 1'b0;
      rdData   <= '0;
      rdValid  <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      ALE      <= 1'b0;
      CLE      <= 1'b0;
      rEn      <= 1'b0;
      cEn      <= 1'b0;
    end else begin
      rdValid <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmdValid) begin
            op_q     <= op_e'(cmdOp);
            addr_q   <= cmdAddr;
            cmdReady <= 1'b0;
            if (op_e'(cmdOp) == OP_RSVD) begin
              state <= ST_DONE;
              done  <= 1'b1;
              error <= 1'b1;
            end else begin
              state <= ST_CMD;
              cEn   <= 1'b1;
              CLE   <= 1'b1;
              wen_q <= 1'b1;
              dio_q <= DIOWidth'(first_code(op_e'(cmdOp)));
            end
          end
        end
        ST_CMD: begin
          state <= ST_ADDR;
          CLE   <= 1'b0;
          ALE   <= 1'b1;
          dio_q <= addr_q;
        end
        ST_ADDR: begin
          ALE <= 1'b0;
          if (op_q == OP_PROG) begin
            state   <= ST_WDATA;
            wen_q   <= 1'b0;
            wrReady <= 1'b1;
            cnt     <= '0;
          end else begin
            state <= ST_CONF;
            CLE   <= 1'b1;
            dio_q <= DIOWidth'(second_code(op_q));
          end
        end
        ST_WDATA: begin
          if (wrValid) begin
            cnt <= cnt + CW'(1);
            if (cnt == LastWord) begin
              state   <= ST_CONF;
              wrReady <= 1'b0;
              CLE     <= 1'b1;
              wen_q   <= 1'b1;
              dio_q   <= DIOWidth'(second_code(op_q));
            end
          end
        end
        ST_CONF: begin
          state <= ST_WAIT;
          CLE   <= 1'b0;
          wen_q <= 1'b0;
        end
        ST_WAIT: begin
          if (status) begin
            if (op_q == OP_READ) begin
              state <= ST_RDATA;
              rEn   <= 1'b1;
              cnt   <= '0;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
              cEn   <= 1'b0;
            end
          end else if (wd_expired) begin
            state <= ST_DONE;
            done  <= 1'b1;
            error <= 1'b1;
            cEn   <= 1'b0;
          end
        end
        ST_RDATA: begin
          // Leaving straight to DONE keeps the cycle after the last rEn undriven
          rdData  <= DIO_memCntrl;
          rdValid <= 1'b1;
          cnt     <= cnt + CW'(1);
          if (cnt == LastWord) begin
            state <= ST_DONE;
            rEn   <= 1'b0;
            done  <= 1'b1;
            cEn   <= 1'b0;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          cmdReady <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          cmdReady <= 1'b1;
        end
      endcase
    end
  end

endmodule
